// File: rtl/stim_check_seq_if.sv
// stim_check_seq_if: groups the run control, status and DUT-facing stimulus/response
// signals of stim_check_seq. The first-error capture signals exist only when the
// STIM_CHECK_FIRST_ERR_EN macro is defined.
interface stim_check_seq_if #(
  parameter int WIDTH = 1
);
  logic             start;
  logic             stop;
  logic [WIDTH-1:0] dut_d;
  logic [WIDTH-1:0] dut_q;
  logic             busy;
  logic             done;
  logic             pass;
  logic [15:0]      err_cnt;
  logic [7:0]       vec_idx;
`ifdef STIM_CHECK_FIRST_ERR_EN
  logic             first_err_valid;
  logic [7:0]       first_err_idx;
  logic [WIDTH-1:0] first_err_q;
`endif

  // sequencer side: drives stimulus and status, receives control and response
  modport master (
    input  start, stop, dut_q,
    output dut_d, busy, done, pass, err_cnt, vec_idx
`ifdef STIM_CHECK_FIRST_ERR_EN
    , output first_err_valid, first_err_idx, first_err_q
`endif
  );

  // environment side: issues start/stop, returns the DUT response, observes status
  modport slave (
    output start, stop, dut_q,
    input  dut_d, busy, done, pass, err_cnt, vec_idx
`ifdef STIM_CHECK_FIRST_ERR_EN
    , input first_err_valid, first_err_idx, first_err_q
`endif
  );
endinterface

// File: rtl/stim_check_seq.sv
// stim_check_seq: drives a fixed table of stimulus vectors onto a DUT and checks the
// response LATENCY edges later against the vector (or its inverse). Optional
// first-error capture is compiled in with the STIM_CHECK_FIRST_ERR_EN macro.
module stim_check_seq #(
  parameter int                       WIDTH   = 1,
  parameter int                       NUM_VEC = 9,
  parameter logic [NUM_VEC*WIDTH-1:0] PATTERN = 9'b000100110,
  parameter int                       LATENCY = 1,
  parameter bit                       EXP_INV = 1'b0,
  parameter bit                       LOOP    = 1'b0
) (
  input logic              clk,
  input logic              rst,
  stim_check_seq_if.master bus
);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RUN   = 2'd1,
    ST_DRAIN = 2'd2,
    ST_DONE  = 2'd3
  } state_t;

  localparam logic [7:0] LAST_IDX   = 8'(NUM_VEC - 1);
  localparam logic [3:0] DRAIN_LAST = 4'(LATENCY);

  // Vector k of the stimulus table.
  function automatic logic [WIDTH-1:0] vec_at(input logic [7:0] k);
    return PATTERN[int'(k)*WIDTH +: WIDTH];
  endfunction

  // Response the DUT is expected to return for a given stimulus vector.
  function automatic logic [WIDTH-1:0] expect_of(input logic [WIDTH-1:0] v);
    logic [WIDTH-1:0] e;
    if (EXP_INV) begin
      e = ~v;
    end else begin
      e = v;
    end
    return e;
  endfunction

  state_t           state_r, state_s;
  logic [3:0]       drain_cnt_r, drain_cnt_s;
  logic             start_s;
  logic             load_s;
  logic [7:0]       load_idx_s;
  logic [WIDTH-1:0] dut_d_r;
  logic [7:0]       vec_idx_r;
  logic [15:0]      err_cnt_r, err_cnt_s;
  logic             busy_r, done_r, pass_r;
  logic [LATENCY:0] pipe_vld_r;
  logic [WIDTH-1:0] pipe_exp_r [0:LATENCY];
  logic             mismatch_s;

  assign start_s    = bus.start && ((state_r == ST_IDLE) || (state_r == ST_DONE));
  assign mismatch_s = pipe_vld_r[LATENCY] && (bus.dut_q != pipe_exp_r[LATENCY]);

  // State and drain-counter registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r     <= ST_IDLE;
      drain_cnt_r <= 4'd0;
    end else begin
      state_r     <= state_s;
      drain_cnt_r <= drain_cnt_s;
    end
  end

  // Next state, and which vector (if any) is loaded onto dut_d at this edge.
  always_comb begin
    state_s     = state_r;
    load_s      = 1'b0;
    load_idx_s  = vec_idx_r;
    drain_cnt_s = drain_cnt_r;
    case (state_r)
      ST_IDLE, ST_DONE: begin
        if (start_s) begin
          state_s    = ST_RUN;
          load_s     = 1'b1;
          load_idx_s = 8'd0;
        end else begin
          state_s = state_r;
        end
      end
      ST_RUN: begin
        drain_cnt_s = 4'd0;
        if (LOOP && bus.stop) begin
          // stop wins over wrap; dut_d freezes on the current vector
          state_s = ST_DRAIN;
        end else if (vec_idx_r == LAST_IDX) begin
          if (LOOP) begin
            load_s     = 1'b1;
            load_idx_s = 8'd0;
          end else begin
            state_s = ST_DRAIN;
          end
        end else begin
          load_s     = 1'b1;
          load_idx_s = vec_idx_r + 8'd1;
        end
      end
      ST_DRAIN: begin
        if (drain_cnt_r == DRAIN_LAST) begin
          state_s = ST_DONE;
        end else begin
          drain_cnt_s = drain_cnt_r + 4'd1;
        end
      end
      default: begin
        state_s = ST_IDLE;
      end
    endcase
  end

  // Error counter: cleared by start, saturating increment on each mismatch.
  always_comb begin
    err_cnt_s = err_cnt_r;
    if (start_s) begin
      err_cnt_s = 16'd0;
    end else if (mismatch_s && (err_cnt_r != 16'hFFFF)) begin
      err_cnt_s = err_cnt_r + 16'd1;
    end else begin
      err_cnt_s = err_cnt_r;
    end
  end

  // Registered stimulus and status outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      dut_d_r   <= '0;
      vec_idx_r <= 8'd0;
      err_cnt_r <= 16'd0;
      busy_r    <= 1'b0;
      done_r    <= 1'b0;
      pass_r    <= 1'b0;
    end else begin
      if (load_s) begin
        dut_d_r   <= vec_at(load_idx_s);
        vec_idx_r <= load_idx_s;
      end
      err_cnt_r <= err_cnt_s;
      busy_r    <= (state_s == ST_RUN) || (state_s == ST_DRAIN);
      done_r    <= (state_s == ST_DONE);
      pass_r    <= (state_s == ST_DONE) && (err_cnt_s == 16'd0);
    end
  end

  // Valid tags of the compare pipeline; a tag enters whenever a vector is loaded.
  always_ff @(posedge clk) begin
    if (rst) begin
      pipe_vld_r <= '0;
    end else begin
      pipe_vld_r[0] <= load_s;
      for (int i = 1; i <= LATENCY; i++) begin
        pipe_vld_r[i] <= pipe_vld_r[i-1];
      end
    end
  end

  // Expected-response payload travelling alongside the valid tags.
  always_ff @(posedge clk) begin
    pipe_exp_r[0] <= expect_of(vec_at(load_idx_s));
    for (int i = 1; i <= LATENCY; i++) begin
      pipe_exp_r[i] <= pipe_exp_r[i-1];
    end
  end

  assign bus.dut_d   = dut_d_r;
  assign bus.vec_idx = vec_idx_r;
  assign bus.err_cnt = err_cnt_r;
  assign bus.busy    = busy_r;
  assign bus.done    = done_r;
  assign bus.pass    = pass_r;

`ifdef STIM_CHECK_FIRST_ERR_EN
  logic [7:0]       pipe_idx_r [0:LATENCY];
  logic             first_err_valid_r;
  logic [7:0]       first_err_idx_r;
  logic [WIDTH-1:0] first_err_q_r;

  // Vector index travelling alongside the expected value.
  always_ff @(posedge clk) begin
    pipe_idx_r[0] <= load_idx_s;
    for (int i = 1; i <= LATENCY; i++) begin
      pipe_idx_r[i] <= pipe_idx_r[i-1];
    end
  end

  // Capture index and response of the first mismatch since start.
  always_ff @(posedge clk) begin
    if (rst) begin
      first_err_valid_r <= 1'b0;
      first_err_idx_r   <= 8'd0;
      first_err_q_r     <= '0;
    end else if (start_s) begin
      first_err_valid_r <= 1'b0;
      first_err_idx_r   <= 8'd0;
      first_err_q_r     <= '0;
    end else if (mismatch_s && !first_err_valid_r) begin
      first_err_valid_r <= 1'b1;
      first_err_idx_r   <= pipe_idx_r[LATENCY];
      first_err_q_r     <= bus.dut_q;
    end
  end

  assign bus.first_err_valid = first_err_valid_r;
  assign bus.first_err_idx   = first_err_idx_r;
  assign bus.first_err_q     = first_err_q_r;
`endif

endmodule

// File: doc/stim_check_seq.md
STIM_CHECK_SEQ -- requirements
Module: stim_check_seq

Interface
REQ-001 SHALL have parameter WIDTH, default 1: stimulus and response width in bits, 1..32.
REQ-002 SHALL have parameter NUM_VEC, default 9: number of stimulus vectors, 1..256.
REQ-003 SHALL have parameter PATTERN, default 9'b000100110, width NUM_VEC*WIDTH: vector k occupies bits [k*WIDTH +: WIDTH].
REQ-004 SHALL have parameter LATENCY, default 1: DUT latency in clock edges, 0..15.
REQ-005 SHALL have parameter EXP_INV, default 0: 1 means the expected response is the bitwise inverse of the stimulus.
REQ-006 SHALL have parameter LOOP, default 0: 1 means the vector index wraps and the run continues until stop.
REQ-007 SHALL have port clk, input, 1: the single clock; all logic is on the rising edge.
REQ-008 SHALL have port rst, input, 1: synchronous, active-high reset.
REQ-009 SHALL have port start, input, 1: begins a run when sampled high in IDLE or DONE.
REQ-010 SHALL have port stop, input, 1: ends a LOOP run; ignored when LOOP=0.
REQ-011 SHALL have port dut_d, output, WIDTH: registered stimulus to the DUT.
REQ-012 SHALL have port dut_q, input, WIDTH: DUT response.
REQ-013 SHALL have port busy, output, 1: high in RUN or DRAIN.
REQ-014 SHALL have port done, output, 1: high in DONE.
REQ-015 SHALL have port pass, output, 1: equals done AND err_cnt==0.
REQ-016 SHALL have port err_cnt, output, 16: count of mismatching comparisons.
REQ-017 SHALL have port vec_idx, output, 8: index of the vector currently on dut_d.

Function
REQ-018 SHALL implement FSM states IDLE, RUN, DRAIN, DONE.
REQ-019 SHALL go IDLE->RUN or DONE->RUN on start=1; on that edge it SHALL load vector 0 onto dut_d, set vec_idx=0 and clear err_cnt.
REQ-020 SHALL, in RUN, advance to vector vec_idx+1 on each edge.
REQ-021 SHALL, in RUN with LOOP=0, go to DRAIN after vector NUM_VEC-1 has been driven for one cycle, with dut_d holding the last vector.
REQ-022 SHALL, in RUN with LOOP=1, wrap vec_idx from NUM_VEC-1 to 0; stop=1 SHALL move the block to DRAIN on the same edge and freeze dut_d.
REQ-023 SHALL compare each vector k driven from cycle c_k against dut_q at the edge ending cycle c_k+LATENCY, using a valid-tagged delay pipeline of depth LATENCY+1.
REQ-024 SHALL use an expected value equal to vector k, or ~vector k when EXP_INV=1; each unequal comparison SHALL increment err_cnt.
REQ-025 SHALL saturate err_cnt at 16'hFFFF.
REQ-026 SHALL stay in DRAIN until the last in-flight comparison has completed (LATENCY+1 edges), then enter DONE.
REQ-027 SHALL hold done, pass and err_cnt in DONE until start or rst.
REQ-028 SHALL ignore start while busy=1.
REQ-029 SHALL give stop priority over wrap when stop and wrap occur on the same edge.

Reset
REQ-030 SHALL, with rst=1 at any edge, including mid-run, enter IDLE and set dut_d=0, vec_idx=0, err_cnt=0, busy=0, done=0, pass=0, and invalidate the compare pipeline.
REQ-031 SHALL give rst priority over start and stop.

Configuration
REQ-032 SHALL compile first-error capture in when macro STIM_CHECK_FIRST_ERR_EN is defined.
REQ-033 SHALL, with STIM_CHECK_FIRST_ERR_EN defined, add outputs first_err_valid (1), first_err_idx (8) and first_err_q (WIDTH).
REQ-034 SHALL, with STIM_CHECK_FIRST_ERR_EN defined, latch the vector index and dut_q of the first mismatch after start and hold them until the next start or rst; these outputs reset to 0.
REQ-035 SHALL, without STIM_CHECK_FIRST_ERR_EN, omit those ports and that logic entirely.

Verification
REQ-036 Defaults, DUT = D flop, start pulse -> dut_d sequence 0,1,1,0,0,1,0,0,0; done rises 11 cycles after start; err_cnt=0; pass=1.
REQ-037 Defaults, DUT = inverter flop -> err_cnt=9, pass=0; with FIRST_ERR_EN, first_err_idx=0 and first_err_q=1.
REQ-038 WIDTH=4, NUM_VEC=4, LATENCY=3, three-stage pipe DUT, one injected bit flip on vector 2 -> err_cnt=1; first_err_idx=2.
REQ-039 LOOP=1, NUM_VEC=9, stop asserted 20 cycles after start -> vec_idx wraps 8->0 twice, then DRAIN, then DONE, with err_cnt=0.
REQ-040 rst pulsed at vector 4 mid-run -> next edge IDLE, all outputs 0; a new start runs the full sequence with pass=1.
REQ-041 start held high for the whole run -> single run only; a fresh run begins the edge after DONE is reached.
